alpha_code_extractor: RTL and testbench

- Reverse path of the stabilizer alpha/global-phase update.
- Consumes a stream of fixed-point complex amplitudes, one per basis index, from the amplitude RAM read port or from the emulation output.
- Captures the first nonzero amplitude as the global phase. Re-encodes every amplitude relative to that phase into the packed 2-bit signed alpha byte that the alpha RAM stores.
- Used to reload a stabilizer state from a dense amplitude vector, and as a self-check of the alpha writer.

---
 rtl/alpha_code_extractor_if.sv | 27 ++
 rtl/alpha_code_extractor.sv | 195 +++++++++++++++++++
 tb/tb_alpha_code_extractor.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/alpha_code_extractor_if.sv
// Stream interface for alpha_code_extractor.
//   in_*  : amplitude input stream (valid/ready), signed real/imag components
//   out_* : encoded alpha byte and its basis index (valid/ready)
// slave is the extractor side, master is the producer/consumer side.
interface alpha_code_extractor_if #(
   parameter int NUM_QUBIT   = 4,
   parameter int COMPLEX_BIT = 24
);
   logic                          in_valid;
   logic                          in_ready;
   logic signed [COMPLEX_BIT-1:0] in_amp_r;
   logic signed [COMPLEX_BIT-1:0] in_amp_i;
   logic                          out_valid;
   logic                          out_ready;
   logic [7:0]                    out_alpha;
   logic [NUM_QUBIT-1:0]          out_index;

   modport master (
      output in_valid, in_amp_r, in_amp_i, out_ready,
      input  in_ready, out_valid, out_alpha, out_index
   );

   modport slave (
      input  in_valid, in_amp_r, in_amp_i, out_ready,
      output in_ready, out_valid, out_alpha, out_index
   );
endinterface

// File: rtl/alpha_code_extractor.sv
// alpha_code_extractor: re-encodes a dense stream of complex amplitudes into
// packed 2-bit signed alpha codes relative to the first nonzero amplitude,
// which is captured as the global phase.
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   start_i      : one-cycle pulse, starts a run when idle
//   bus          : amplitude input stream and alpha output stream (slave)
//   gp_r_o/gp_i_o: captured global phase; gp_valid_o once captured
//   busy_o       : run in progress
//   done_o       : pulses on the final output handshake
//   error_o      : sticky per run; unmatched amplitude or all-zero vector
// Matching is done directly in LSBs, so the fractional-bit position of the
// fixed-point format does not enter the logic.
//
// state  | meaning
// IDLE   | waiting for start
// SEEK   | no global phase captured yet
// ENCODE | global phase held, encoding relative to it
// LAST   | final amplitude accepted, draining its output
module alpha_code_extractor #(
   parameter int NUM_QUBIT   = 4,
   parameter int COMPLEX_BIT = 24,
   parameter int TOL         = 4
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          start_i,
   alpha_code_extractor_if.slave         bus,
   output logic signed [COMPLEX_BIT-1:0] gp_r_o,
   output logic signed [COMPLEX_BIT-1:0] gp_i_o,
   output logic                          gp_valid_o,
   output logic                          busy_o,
   output logic                          done_o,
   output logic                          error_o
);
   // One extra bit so differences and negation of the most negative value never wrap.
   localparam int W = COMPLEX_BIT + 1;
   typedef logic signed [W-1:0] ext_t;

   typedef enum logic [1:0] {IDLE, SEEK, ENCODE, LAST} state_t;

   state_t                        state_q, state_d;
   logic [NUM_QUBIT-1:0]          cnt_q, cnt_d;
   logic [NUM_QUBIT-1:0]          out_index_q, out_index_d;
   logic [7:0]                    out_alpha_q, out_alpha_d;
   logic                          out_valid_q, out_valid_d;
   logic signed [COMPLEX_BIT-1:0] gp_r_q, gp_r_d, gp_i_q, gp_i_d;
   logic                          gp_valid_q, gp_valid_d;
   logic                          error_q, error_d;
   logic                          done;

   logic in_ready, accept, out_hs, last_in;
   ext_t ar, ai, gr, gi;
   logic is_zero, miss;
   logic [7:0] code;

   function automatic logic near(input ext_t a, input ext_t b);
      ext_t d;
      d = a - b;
      return (d <= ext_t'(TOL)) && (d >= -ext_t'(TOL));
   endfunction

   assign ar = ext_t'(bus.in_amp_r);
   assign ai = ext_t'(bus.in_amp_i);
   assign gr = ext_t'(gp_r_q);
   assign gi = ext_t'(gp_i_q);

   assign in_ready = ((state_q == SEEK) || (state_q == ENCODE)) &&
                     (!out_valid_q || bus.out_ready);
   assign accept   = bus.in_valid && in_ready;
   assign out_hs   = out_valid_q && bus.out_ready;
   assign last_in  = (cnt_q == {NUM_QUBIT{1'b1}});
   assign is_zero  = near(ar, ext_t'(0)) && near(ai, ext_t'(0));

   // Priority: zero, +g, -g, +i*g, -i*g.
   always_comb begin
      code = 8'h00;
      miss = 1'b0;
      if (is_zero)
         code = 8'h00;
      else if (near(ar, gr) && near(ai, gi))
         code = 8'h04;
      else if (near(ar, -gr) && near(ai, -gi))
         code = 8'h0C;
      else if (near(ar, -gi) && near(ai, gr))
         code = 8'h01;
      else if (near(ar, gi) && near(ai, -gr))
         code = 8'h03;
      else
         miss = 1'b1;
   end

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      out_index_d = out_index_q;
      out_alpha_d = out_alpha_q;
      out_valid_d = out_valid_q;
      gp_r_d      = gp_r_q;
      gp_i_d      = gp_i_q;
      gp_valid_d  = gp_valid_q;
      error_d     = error_q;
      done        = 1'b0;

      if (out_hs)
         out_valid_d = 1'b0;

      if (accept) begin
         out_valid_d = 1'b1;
         out_index_d = cnt_q;
         cnt_d       = cnt_q + NUM_QUBIT'(1);
      end

      case (state_q)
         IDLE: begin
            if (start_i) begin
               state_d    = SEEK;
               cnt_d      = '0;
               error_d    = 1'b0;
               gp_valid_d = 1'b0;
               gp_r_d     = '0;
               gp_i_d     = '0;
            end
         end
         SEEK: begin
            if (accept) begin
               if (is_zero) begin
                  out_alpha_d = 8'h00;
                  if (last_in) begin
                     error_d = 1'b1;
                     state_d = LAST;
                  end
               end else begin
                  out_alpha_d = 8'h04;
                  gp_r_d      = bus.in_amp_r;
                  gp_i_d      = bus.in_amp_i;
                  gp_valid_d  = 1'b1;
                  state_d     = last_in ? LAST : ENCODE;
               end
            end
         end
         ENCODE: begin
            if (accept) begin
               out_alpha_d = code;
               if (miss)
                  error_d = 1'b1;
               if (last_in)
                  state_d = LAST;
            end
         end
         LAST: begin
            if (out_hs) begin
               done    = 1'b1;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         out_index_q <= '0;
         out_alpha_q <= '0;
         out_valid_q <= 1'b0;
         gp_r_q      <= '0;
         gp_i_q      <= '0;
         gp_valid_q  <= 1'b0;
         error_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         out_index_q <= out_index_d;
         out_alpha_q <= out_alpha_d;
         out_valid_q <= out_valid_d;
         gp_r_q      <= gp_r_d;
         gp_i_q      <= gp_i_d;
         gp_valid_q  <= gp_valid_d;
         error_q     <= error_d;
      end
   end

   assign bus.in_ready  = in_ready;
   assign bus.out_valid = out_valid_q;
   assign bus.out_alpha = out_alpha_q;
   assign bus.out_index = out_index_q;
   assign gp_r_o        = gp_r_q;
   assign gp_i_o        = gp_i_q;
   assign gp_valid_o    = gp_valid_q;
   assign error_o       = error_q;
   assign busy_o        = (state_q != IDLE);
   assign done_o        = done;
endmodule

// File: tb/tb_alpha_code_extractor.sv
module tb_alpha_code_extractor;
   localparam int NQ = 2;
   localparam int CB = 24;
   localparam int NS = 6;
   localparam logic signed [CB-1:0] H  = 24'sd2965821;
   localparam logic signed [CB-1:0] H2 = 24'sd1482910;
   localparam logic signed [CB-1:0] MN = 24'sh800000;
   localparam logic signed [CB-1:0] MX = 24'sh7FFFFF;

   typedef struct {
      logic signed [CB-1:0] r;
      logic signed [CB-1:0] i;
      logic [7:0]           alpha;
      logic                 err;
      logic                 gpv;
   } vec_t;

   typedef struct {
      logic signed [CB-1:0] gr;
      logic signed [CB-1:0] gi;
      logic                 gpv;
      logic                 err;
   } res_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic start = 1'b0;
   logic signed [CB-1:0] gp_r, gp_i;
   logic gp_valid, busy, done, error;

   int tests = 0;
   int failed = 0;
   int done_cnt = 0;

   vec_t vt[NS*4];
   res_t rt[NS];

   always #5 clk = ~clk;

   alpha_code_extractor_if #(.NUM_QUBIT(NQ), .COMPLEX_BIT(CB)) bus();

   alpha_code_extractor #(.NUM_QUBIT(NQ), .COMPLEX_BIT(CB), .TOL(4)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start_i   (start),
      .bus       (bus),
      .gp_r_o    (gp_r),
      .gp_i_o    (gp_i),
      .gp_valid_o(gp_valid),
      .busy_o    (busy),
      .done_o    (done),
      .error_o   (error)
   );

   always @(negedge clk) if (done) done_cnt++;

   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         failed++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic pulse_start();
      @(negedge clk) start = 1'b1;
      @(negedge clk) start = 1'b0;
   endtask

   task automatic feed(input vec_t v, input int idx, input string tag);
      int n;
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.in_amp_r = v.r;
      bus.in_amp_i = v.i;
      n = 0;
      while (!bus.in_ready && n < 16) begin
         @(negedge clk);
         n++;
      end
      chk($sformatf("%s[%0d] in_ready", tag, idx), 32'(bus.in_ready), 32'd1);
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      chk($sformatf("%s[%0d] out_valid", tag, idx), 32'(bus.out_valid), 32'd1);
      chk($sformatf("%s[%0d] alpha", tag, idx), 32'(bus.out_alpha), 32'(v.alpha));
      chk($sformatf("%s[%0d] index", tag, idx), 32'(bus.out_index), 32'(idx));
      chk($sformatf("%s[%0d] error", tag, idx), 32'(error), 32'(v.err));
      chk($sformatf("%s[%0d] gp_valid", tag, idx), 32'(gp_valid), 32'(v.gpv));
   endtask

   task automatic finish_run(input res_t e, input int dc0, input string tag);
      repeat (3) @(negedge clk);
      chk({tag, " done count"}, 32'(done_cnt), 32'(dc0 + 1));
      chk({tag, " busy"}, 32'(busy), 32'd0);
      chk({tag, " out_valid"}, 32'(bus.out_valid), 32'd0);
      chk({tag, " gp_r"}, 32'(gp_r), 32'(e.gr));
      chk({tag, " gp_i"}, 32'(gp_i), 32'(e.gi));
      chk({tag, " gp_valid"}, 32'(gp_valid), 32'(e.gpv));
      chk({tag, " error"}, 32'(error), 32'(e.err));
   endtask

   initial begin
      int dc;
      // basic stream
      vt[0]  = '{H, 0, 8'h04, 1'b0, 1'b1};
      vt[1]  = '{0, 0, 8'h00, 1'b0, 1'b1};
      vt[2]  = '{H, 0, 8'h04, 1'b0, 1'b1};
      vt[3]  = '{0, 0, 8'h00, 1'b0, 1'b1};
      rt[0]  = '{H, 0, 1'b1, 1'b0};
      // phase captured at index 1, -i*g and -g codes
      vt[4]  = '{0, 0, 8'h00, 1'b0, 1'b0};
      vt[5]  = '{0, H, 8'h04, 1'b0, 1'b1};
      vt[6]  = '{H, 0, 8'h03, 1'b0, 1'b1};
      vt[7]  = '{0, -H, 8'h0C, 1'b0, 1'b1};
      rt[1]  = '{0, H, 1'b1, 1'b0};
      // unmatched amplitude sets sticky error
      vt[8]  = '{H, 0, 8'h04, 1'b0, 1'b1};
      vt[9]  = '{H2, 0, 8'h00, 1'b1, 1'b1};
      vt[10] = '{0, -H, 8'h03, 1'b1, 1'b1};
      vt[11] = '{0, 0, 8'h00, 1'b1, 1'b1};
      rt[2]  = '{H, 0, 1'b1, 1'b1};
      // all-zero vector
      vt[12] = '{0, 0, 8'h00, 1'b0, 1'b0};
      vt[13] = '{3, -4, 8'h00, 1'b0, 1'b0};
      vt[14] = '{-4, 2, 8'h00, 1'b0, 1'b0};
      vt[15] = '{0, 0, 8'h00, 1'b1, 1'b0};
      rt[3]  = '{0, 0, 1'b0, 1'b1};
      // tolerance edges; error cleared by start
      vt[16] = '{H + 2, -3, 8'h04, 1'b0, 1'b1};
      vt[17] = '{0, 0, 8'h00, 1'b0, 1'b1};
      vt[18] = '{-H + 1, 0, 8'h0C, 1'b0, 1'b1};
      vt[19] = '{0, 0, 8'h00, 1'b0, 1'b1};
      rt[4]  = '{H + 2, -3, 1'b1, 1'b0};
      // most negative phase: negation must not wrap
      vt[20] = '{MN, 0, 8'h04, 1'b0, 1'b1};
      vt[21] = '{MX, 0, 8'h0C, 1'b0, 1'b1};
      vt[22] = '{0, MN, 8'h01, 1'b0, 1'b1};
      vt[23] = '{1, -2, 8'h00, 1'b0, 1'b1};
      rt[5]  = '{MN, 0, 1'b1, 1'b0};

      bus.in_valid  = 1'b0;
      bus.in_amp_r  = '0;
      bus.in_amp_i  = '0;
      bus.out_ready = 1'b1;

      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      chk("reset out_valid", 32'(bus.out_valid), 32'd0);
      chk("reset out_alpha", 32'(bus.out_alpha), 32'd0);
      chk("reset out_index", 32'(bus.out_index), 32'd0);
      chk("reset gp_valid", 32'(gp_valid), 32'd0);
      chk("reset busy", 32'(busy), 32'd0);
      chk("reset error", 32'(error), 32'd0);

      // in_valid while idle is not accepted
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.in_amp_r = H;
      #1;
      chk("idle in_ready", 32'(bus.in_ready), 32'd0);
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      chk("idle out_valid", 32'(bus.out_valid), 32'd0);
      chk("idle busy", 32'(busy), 32'd0);

      for (int s = 0; s < NS; s++) begin
         dc = done_cnt;
         pulse_start();
         for (int k = 0; k < 4; k++)
            feed(vt[s*4 + k], k, $sformatf("scn%0d", s));
         finish_run(rt[s], dc, $sformatf("scn%0d", s));
      end

      // backpressure: output held while out_ready is low
      dc = done_cnt;
      pulse_start();
      feed(vt[0], 0, "hold");
      bus.out_ready = 1'b0;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         chk($sformatf("hold%0d in_ready", c), 32'(bus.in_ready), 32'd0);
         chk($sformatf("hold%0d out_valid", c), 32'(bus.out_valid), 32'd1);
         chk($sformatf("hold%0d alpha", c), 32'(bus.out_alpha), 32'h04);
         chk($sformatf("hold%0d index", c), 32'(bus.out_index), 32'd0);
      end
      @(negedge clk) bus.out_ready = 1'b1;
      for (int k = 1; k < 4; k++) feed(vt[k], k, "hold");
      finish_run(rt[0], dc, "hold");

      // asynchronous reset mid-run
      pulse_start();
      feed(vt[0], 0, "rst");
      feed(vt[1], 1, "rst");
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("arst out_valid", 32'(bus.out_valid), 32'd0);
      chk("arst out_alpha", 32'(bus.out_alpha), 32'd0);
      chk("arst out_index", 32'(bus.out_index), 32'd0);
      chk("arst gp_r", 32'(gp_r), 32'd0);
      chk("arst gp_i", 32'(gp_i), 32'd0);
      chk("arst gp_valid", 32'(gp_valid), 32'd0);
      chk("arst busy", 32'(busy), 32'd0);
      chk("arst error", 32'(error), 32'd0);
      chk("arst done", 32'(done), 32'd0);
      @(negedge clk) rst_n = 1'b1;

      // replay with a start pulse mid-run that must be ignored
      dc = done_cnt;
      pulse_start();
      feed(vt[0], 0, "replay");
      feed(vt[1], 1, "replay");
      pulse_start();
      chk("replay busy", 32'(busy), 32'd1);
      feed(vt[2], 2, "replay");
      feed(vt[3], 3, "replay");
      finish_run(rt[0], dc, "replay");

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end
endmodule
